// File: rtl/vmem24_pkg.sv
// Shared types and constants for the 24-bpp video-memory write path.
// The memory is organised as 64-bit words. A pixel occupies 3 bytes at byte address index*3.
// A pixel starting at byte offset 6 or 7 within a word straddles into the next word.
package vmem24_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SH0,
    ST_WR0,
    ST_SH1,
    ST_WR1
  } state_t;

  localparam int unsigned BYTES_PER_PIX = 3;
  localparam int unsigned STRADDLE_OFF  = 6;
  localparam int unsigned VOFF_HI2      = 8;  // second write carries rgb[23:8]
  localparam int unsigned VOFF_HI1      = 9;  // second write carries rgb[23:16]

  localparam logic [63:0] MASK_1B = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] MASK_2B = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] MASK_3B = 64'h0000_0000_00FF_FFFF;

  // Shifter offset for the second word of a straddling pixel.
  // Offset 6 has already written 2 bytes, so 1 byte remains (voff 9).
  // Offset 7 has already written 1 byte, so 2 bytes remain (voff 8).
  function automatic logic [3:0] tail_voff(input logic [2:0] off);
    return (off == 3'(STRADDLE_OFF)) ? 4'(VOFF_HI1) : 4'(VOFF_HI2);
  endfunction

endpackage

// File: rtl/vmem24_lane_shift.sv
// Registered 24->64 lane shifter for vmem writes.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  synchronous active-low reset; clears data_o and mask_o
//   en_i    load a new result this cycle; otherwise hold the previous result
//   rgb_i   pixel colour {R,G,B}
//   off_i   lane offset 0..9 (8/9 are virtual offsets for the tail of a straddling pixel)
//   data_o  lane-shifted data; unused lanes are 0
//   mask_o  per-bit write enable, byte granular
module vmem24_lane_shift
  import vmem24_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [23:0] rgb_i,
  input  logic [3:0]  off_i,
  output logic [63:0] data_o,
  output logic [63:0] mask_o
);

  logic [63:0] data_d, mask_d;
  logic [63:0] data_q, mask_q;

  always_comb begin
    data_d = '0;
    mask_d = '0;
    case (off_i)
      4'd0: begin data_d = {40'h0, rgb_i};        mask_d = MASK_3B;       end
      4'd1: begin data_d = {32'h0, rgb_i, 8'h0};  mask_d = MASK_3B << 8;  end
      4'd2: begin data_d = {24'h0, rgb_i, 16'h0}; mask_d = MASK_3B << 16; end
      4'd3: begin data_d = {16'h0, rgb_i, 24'h0}; mask_d = MASK_3B << 24; end
      4'd4: begin data_d = {8'h0, rgb_i, 32'h0};  mask_d = MASK_3B << 32; end
      4'd5: begin data_d = {rgb_i, 40'h0};        mask_d = MASK_3B << 40; end
      4'd6: begin data_d = {rgb_i[15:0], 48'h0};  mask_d = MASK_2B << 48; end
      4'd7: begin data_d = {rgb_i[7:0], 56'h0};   mask_d = MASK_1B << 56; end
      4'd8: begin data_d = {48'h0, rgb_i[23:8]};  mask_d = MASK_2B;       end
      4'd9: begin data_d = {56'h0, rgb_i[23:16]}; mask_d = MASK_1B;       end
      default: begin data_d = '0; mask_d = '0; end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
      mask_q <= '0;
    end else if (en_i) begin
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  assign data_o = data_q;
  assign mask_o = mask_q;

endmodule

// File: rtl/vmem24_write_seq.sv
// Write sequencer for 24-bpp video memory packed into 64-bit words.
// Accepts one pixel per handshake, computes byte address index*3, and issues one masked
// 64-bit write, or two when the pixel straddles a word boundary (byte offset 6 or 7).
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   pix_valid  pixel request valid
//   pix_ready  registered; high exactly while idle (low in reset)
//   pix_index  linear pixel index
//   pix_rgb    pixel colour {R,G,B}, B in bits 7:0
//   mem_we     write request, held with stable addr/data/mask until mem_ack
//   mem_addr   64-bit word address, wraps modulo 2^ADDR_W
//   mem_data   lane-shifted write data
//   mem_mask   per-bit write enable
//   mem_ack    write accepted (ignored while mem_we=0)
//   busy       high whenever not idle
module vmem24_write_seq
  import vmem24_pkg::*;
#(
  parameter int unsigned IDX_W  = 20,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [IDX_W-1:0]  pix_index,
  input  logic [23:0]       pix_rgb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_data,
  output logic [63:0]       mem_mask,
  input  logic              mem_ack,
  output logic              busy
);

  state_t state_q, state_d;

  logic [23:0]       rgb_q;
  logic [2:0]        off_q;
  logic [ADDR_W-1:0] word_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              rdy_q;

  logic [IDX_W+1:0]  byte_c;
  logic              accept;
  logic              shift_en;
  logic [3:0]        shift_off;

  // index*3 as (index<<1)+index, widened so no carry is lost.
  assign byte_c = ({2'b00, pix_index} << 1) + {2'b00, pix_index};
  assign accept = pix_valid & rdy_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SH0;
      ST_SH0:  state_d = ST_WR0;
      ST_WR0:  if (mem_ack) state_d = (off_q >= 3'(STRADDLE_OFF)) ? ST_SH1 : ST_IDLE;
      ST_SH1:  state_d = ST_WR1;
      ST_WR1:  if (mem_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The shifter only loads in the SH states, so its output stays frozen through the
  // WR states and while idle.
  always_comb begin
    shift_en  = (state_q == ST_SH0) || (state_q == ST_SH1);
    shift_off = (state_q == ST_SH1) ? tail_voff(off_q) : {1'b0, off_q};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rgb_q   <= '0;
      off_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ST_IDLE);
      we_q    <= (state_d == ST_WR0) || (state_d == ST_WR1);
      if (accept) begin
        rgb_q  <= pix_rgb;
        off_q  <= byte_c[2:0];
        word_q <= ADDR_W'(byte_c >> 3);
      end
      if (state_q == ST_SH0) addr_q <= word_q;
      if (state_q == ST_SH1) addr_q <= word_q + ADDR_W'(1);
    end
  end

  vmem24_lane_shift u_shift (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (shift_en),
    .rgb_i  (rgb_q),
    .off_i  (shift_off),
    .data_o (mem_data),
    .mask_o (mem_mask)
  );

  assign pix_ready = rdy_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vmem24_write_seq.sv
module tb_vmem24_write_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [19:0] pix_index;
  logic [23:0] pix_rgb;
  logic        mem_ack;

  logic        pix_ready, mem_we, busy;
  logic [18:0] mem_addr;
  logic [63:0] mem_data, mem_mask;

  logic        pix_ready4, mem_we4, busy4;
  logic [3:0]  mem_addr4;
  logic [63:0] mem_data4, mem_mask4;

  always #5 clk = ~clk;

  vmem24_write_seq #(.IDX_W(20), .ADDR_W(19)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_index(pix_index), .pix_rgb(pix_rgb), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_mask(mem_mask), .mem_ack(mem_ack), .busy(busy)
  );

  vmem24_write_seq #(.IDX_W(20), .ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready4),
    .pix_index(pix_index), .pix_rgb(pix_rgb), .mem_we(mem_we4), .mem_addr(mem_addr4),
    .mem_data(mem_data4), .mem_mask(mem_mask4), .mem_ack(mem_ack), .busy(busy4)
  );

  // Write monitor: logs every accepted write (mem_we & mem_ack at a rising edge).
  logic [18:0] w_addr  [64];
  logic [3:0]  w4_addr [64];
  logic [63:0] w_data  [64];
  logic [63:0] w_mask  [64];
  int          w_cnt  = 0;
  int          we_cyc = 0;

  always @(posedge clk) begin
    if (rst && mem_we) begin
      we_cyc <= we_cyc + 1;
      if (mem_ack && w_cnt < 64) begin
        w_addr[w_cnt]  <= mem_addr;
        w4_addr[w_cnt] <= mem_addr4;
        w_data[w_cnt]  <= mem_data;
        w_mask[w_cnt]  <= mem_mask;
        w_cnt          <= w_cnt + 1;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks start and end at a point 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [19:0] idx, input logic [23:0] rgb);
    bit ok = 1'b0;
    pix_index = idx;
    pix_rgb   = rgb;
    pix_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (pix_ready) begin ok = 1'b1; break; end
      step();
    end
    chk("ready_timeout", {63'b0, ok}, 64'd1);
    step();
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (pix_ready && !busy) begin ok = 1'b1; break; end
      step();
    end
    chk("idle_timeout", {63'b0, ok}, 64'd1);
  endtask

  task automatic wait_we();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_we) begin ok = 1'b1; break; end
      step();
    end
    chk("we_timeout", {63'b0, ok}, 64'd1);
  endtask

  typedef struct {
    logic [19:0] idx;
    logic [23:0] rgb;
    int          n;
    logic [18:0] a0;
    logic [63:0] d0;
    logic [63:0] m0;
    logic [18:0] a1;
    logic [63:0] d1;
    logic [63:0] m1;
  } vec_t;

  vec_t vt[8];

  initial begin
    int base, wc0;

    vt[0] = '{20'd0,  24'hABCDEF, 1, 19'd0, 64'h0000_0000_00AB_CDEF, 64'h0000_0000_00FF_FFFF, 19'd0, 64'h0, 64'h0};
    vt[1] = '{20'd2,  24'hABCDEF, 2, 19'd0, 64'hCDEF_0000_0000_0000, 64'hFFFF_0000_0000_0000, 19'd1, 64'hAB, 64'hFF};
    vt[2] = '{20'd5,  24'hABCDEF, 2, 19'd1, 64'hEF00_0000_0000_0000, 64'hFF00_0000_0000_0000, 19'd2, 64'hABCD, 64'hFFFF};
    vt[3] = '{20'd1,  24'hABCDEF, 1, 19'd0, 64'h0000_ABCD_EF00_0000, 64'h0000_FFFF_FF00_0000, 19'd0, 64'h0, 64'h0};
    vt[4] = '{20'd3,  24'h00FF01, 1, 19'd1, 64'h0000_0000_00FF_0100, 64'h0000_0000_FFFF_FF00, 19'd0, 64'h0, 64'h0};
    vt[5] = '{20'd4,  24'h800001, 1, 19'd1, 64'h0080_0001_0000_0000, 64'h00FF_FFFF_0000_0000, 19'd0, 64'h0, 64'h0};
    vt[6] = '{20'd10, 24'h123456, 2, 19'd3, 64'h3456_0000_0000_0000, 64'hFFFF_0000_0000_0000, 19'd4, 64'h12, 64'hFF};
    vt[7] = '{20'hFFFFF, 24'hABCDEF, 1, 19'h5FFFF, 64'hABCD_EF00_0000_0000, 64'hFFFF_FF00_0000_0000, 19'd0, 64'h0, 64'h0};

    rst = 1'b0; pix_valid = 1'b0; pix_index = '0; pix_rgb = '0; mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'b0, pix_ready}, 64'd0);
    chk("rst_we",    {63'b0, mem_we},    64'd0);
    chk("rst_busy",  {63'b0, busy},      64'd0);
    chk("rst_addr",  {45'b0, mem_addr},  64'd0);
    chk("rst_data",  mem_data,           64'd0);
    chk("rst_mask",  mem_mask,           64'd0);
    rst = 1'b1;
    step();
    chk("ready_after_rst", {63'b0, pix_ready}, 64'd1);

    // Table of single pixels with immediate ack.
    for (int v = 0; v < 8; v++) begin
      base = w_cnt; wc0 = we_cyc;
      send_pixel(vt[v].idx, vt[v].rgb);
      wait_idle();
      chk($sformatf("v%0d_nwr", v),   64'(w_cnt - base),  64'(vt[v].n));
      chk($sformatf("v%0d_wecyc", v), 64'(we_cyc - wc0),  64'(vt[v].n));
      chk($sformatf("v%0d_a0", v), {45'b0, w_addr[base]}, {45'b0, vt[v].a0});
      chk($sformatf("v%0d_d0", v), w_data[base], vt[v].d0);
      chk($sformatf("v%0d_m0", v), w_mask[base], vt[v].m0);
      if (vt[v].n == 2) begin
        chk($sformatf("v%0d_a1", v), {45'b0, w_addr[base+1]}, {45'b0, vt[v].a1});
        chk($sformatf("v%0d_d1", v), w_data[base+1], vt[v].d1);
        chk($sformatf("v%0d_m1", v), w_mask[base+1], vt[v].m1);
      end
    end

    // Ack withheld for 4 cycles: outputs must hold.
    mem_ack = 1'b0;
    base = w_cnt; wc0 = we_cyc;
    send_pixel(20'd1, 24'hABCDEF);
    wait_we();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold%0d_we", i),    {63'b0, mem_we},    64'd1);
      chk($sformatf("hold%0d_addr", i),  {45'b0, mem_addr},  64'd0);
      chk($sformatf("hold%0d_data", i),  mem_data, 64'h0000_ABCD_EF00_0000);
      chk($sformatf("hold%0d_mask", i),  mem_mask, 64'h0000_FFFF_FF00_0000);
      chk($sformatf("hold%0d_ready", i), {63'b0, pix_ready}, 64'd0);
      chk($sformatf("hold%0d_busy", i),  {63'b0, busy},      64'd1);
      step();
    end
    mem_ack = 1'b1;
    wait_idle();
    chk("hold_nwr",   64'(w_cnt - base), 64'd1);
    chk("hold_wecyc", 64'(we_cyc - wc0), 64'd5);
    chk("hold_idle_data", mem_data, 64'h0000_ABCD_EF00_0000);

    // Word address wrap with ADDR_W=4: byte 126 = word 15, offset 6.
    base = w_cnt;
    send_pixel(20'd42, 24'hABCDEF);
    wait_idle();
    chk("wrap_nwr", 64'(w_cnt - base), 64'd2);
    chk("wrap_a0",  {60'b0, w4_addr[base]},   64'd15);
    chk("wrap_a1",  {60'b0, w4_addr[base+1]}, 64'd0);
    chk("wide_a0",  {45'b0, w_addr[base]},    64'd15);
    chk("wide_a1",  {45'b0, w_addr[base+1]},  64'd16);
    chk("wrap_busy",  {63'b0, busy4},      64'd0);
    chk("wrap_ready", {63'b0, pix_ready4}, 64'd1);
    chk("wrap_d1",  mem_data4, 64'hAB);

    // Reset while WR1 is waiting for ack.
    mem_ack = 1'b0;
    send_pixel(20'd2, 24'hABCDEF);
    wait_we();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    wait_we();
    chk("wr1_addr", {45'b0, mem_addr}, 64'd1);
    base = w_cnt;
    rst = 1'b0;
    step();
    chk("mid_rst_we",    {63'b0, mem_we},    64'd0);
    chk("mid_rst_ready", {63'b0, pix_ready}, 64'd0);
    chk("mid_rst_busy",  {63'b0, busy},      64'd0);
    chk("mid_rst_data",  mem_data,           64'd0);
    rst = 1'b1;
    step();
    chk("post_rst_ready", {63'b0, pix_ready}, 64'd1);
    mem_ack = 1'b1;
    repeat (5) step();
    chk("post_rst_nowr", 64'(w_cnt - base), 64'd0);

    // Back-to-back stream of 3 pixels.
    base = w_cnt;
    send_pixel(20'd0, 24'h111111);
    send_pixel(20'd1, 24'h222222);
    send_pixel(20'd2, 24'h333333);
    wait_idle();
    chk("strm_nwr", 64'(w_cnt - base), 64'd4);
    chk("strm_a0", {45'b0, w_addr[base]},   64'd0);
    chk("strm_a1", {45'b0, w_addr[base+1]}, 64'd0);
    chk("strm_a2", {45'b0, w_addr[base+2]}, 64'd0);
    chk("strm_a3", {45'b0, w_addr[base+3]}, 64'd1);
    chk("strm_d0", w_data[base],   64'h0000_0000_0011_1111);
    chk("strm_d1", w_data[base+1], 64'h0000_2222_2200_0000);
    chk("strm_d2", w_data[base+2], 64'h3333_0000_0000_0000);
    chk("strm_d3", w_data[base+3], 64'h33);
    chk("strm_m3", w_mask[base+3], 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
